pc_fetch_ctrl: RTL and testbench

Program-counter and fetch sequencer that sits directly downstream of the jump controller. It consumes the 2-bit jump select, holds the architectural PC, and fetches instructions from instruction memory over a req/ready handshake. It presents each instruction to decode/execute and advances the PC when execute signals commit. It also produces the link address for jal/jalr, flags misaligned register jumps, and counts control-flow redirects.

---
 rtl/pc_fetch_ctrl_pkg.sv | 18 +
 rtl/pc_fetch_ctrl_next_pc_calc.sv | 32 +++
 rtl/pc_fetch_ctrl.sv | 155 +++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_ctrl_pkg.sv
// rtl/pc_fetch_ctrl_pkg.sv - shared jump_op encodings, fetch states and reset PC
package pc_fetch_ctrl_pkg;

    // next-PC select codes; the jump controller drives these same values
    localparam logic [1:0] JOP_TARGET = 2'd0;
    localparam logic [1:0] JOP_REG    = 2'd1;
    localparam logic [1:0] JOP_BRANCH = 2'd2;
    localparam logic [1:0] JOP_SEQ    = 2'd3;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_fetch_ctrl_next_pc_calc.sv
// rtl/pc_fetch_ctrl_next_pc_calc.sv - combinational next-PC select and misaligned-target detect
module pc_fetch_ctrl_next_pc_calc
    import pc_fetch_ctrl_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [25:0] instr_idx,
    input  logic [31:0] rs_data,
    input  logic [1:0]  jump_op,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] pc4;

    // select the successor PC; only the low 26 instruction bits are ever needed
    always_comb begin
        pc4        = pc + 32'd4;
        next_pc    = pc4;
        misaligned = 1'b0;
        case (jump_op)
            JOP_TARGET: next_pc = {pc4[31:28], instr_idx, 2'b00};
            JOP_REG: begin
                next_pc    = rs_data;
                misaligned = (rs_data[1:0] != 2'b00);
            end
            JOP_BRANCH: next_pc = pc4 + {{14{instr_idx[15]}}, instr_idx[15:0], 2'b00};
            JOP_SEQ:    next_pc = pc4;
            default:    next_pc = pc4;
        endcase
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - PC register and fetch/issue sequencer; optional MIPS_DELAY_SLOT_EN
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       jump_op,
    input  logic [31:0]      rs_data,
    input  logic             commit,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr,
    output logic             instr_valid,
    output logic [31:0]      pc,
    output logic [31:0]      link_addr,
    output logic             misalign,
    output logic [CNT_W-1:0] redirect_cnt
);

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic [31:0]       pc_q;
    logic [31:0]       instr_q;
    logic              misalign_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       calc_pc;
    logic              calc_misaligned;
    logic              commit_fire;
    logic              take_redirect;
    logic              halt_now;

    pc_fetch_ctrl_next_pc_calc u_next_pc_calc (
        .pc         (pc_q),
        .instr_idx  (instr_q[25:0]),
        .rs_data    (rs_data),
        .jump_op    (jump_op),
        .next_pc    (calc_pc),
        .misaligned (calc_misaligned)
    );

    assign commit_fire = (state == ST_ISSUE) && commit;

`ifdef MIPS_DELAY_SLOT_EN
    logic        pending_q;
    logic [31:0] pending_pc_q;

    // the delay-slot commit follows the stored target and skips the jump checks
    assign halt_now      = commit_fire && !pending_q && calc_misaligned;
    assign take_redirect = commit_fire && !pending_q && !calc_misaligned && (jump_op != JOP_SEQ);
    assign link_addr     = pc_q + 32'd8;

    // delay-slot bookkeeping: remember the redirect target until the slot commits
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q    <= 1'b0;
            pending_pc_q <= 32'h0;
        end else if (commit_fire) begin
            if (pending_q) begin
                pending_q <= 1'b0;
            end else if (take_redirect) begin
                pending_q    <= 1'b1;
                pending_pc_q <= calc_pc;
            end
        end
    end

    // PC update: redirects first step into the slot, the slot then jumps
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (commit_fire && !halt_now) begin
            if (pending_q)
                pc_q <= pending_pc_q;
            else
                pc_q <= pc_q + 32'd4;
        end
    end
`else
    assign halt_now      = commit_fire && calc_misaligned;
    assign take_redirect = commit_fire && !calc_misaligned && (jump_op != JOP_SEQ);
    assign link_addr     = pc_q + 32'd4;

    // PC update: redirects take effect on the committing instruction itself
    always_ff @(posedge clk) begin
        if (!rst_n)
            pc_q <= RESET_PC;
        else if (commit_fire && !halt_now)
            pc_q <= calc_pc;
    end
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= ST_FETCH;
        else
            state <= state_nxt;
    end

    // FSM next state and handshake outputs
    always_comb begin
        state_nxt   = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state)
            ST_FETCH: begin
                imem_req = rst_n;
                if (imem_ready)
                    state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                instr_valid = 1'b1;
                if (halt_now)
                    state_nxt = ST_HALT;
                else if (commit)
                    state_nxt = ST_FETCH;
            end
            ST_HALT:  state_nxt = ST_HALT;
            default:  state_nxt = ST_FETCH;
        endcase
    end

    // instruction latch; ready outside FETCH is ignored
    always_ff @(posedge clk) begin
        if (!rst_n)
            instr_q <= 32'h0;
        else if ((state == ST_FETCH) && imem_ready)
            instr_q <= imem_rdata;
    end

    // sticky misalign flag and saturating redirect counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            if (halt_now)
                misalign_q <= 1'b1;
            if (take_redirect && (cnt_q != {CNT_W{1'b1}}))
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign imem_addr    = pc_q;
    assign pc           = pc_q;
    assign instr        = instr_q;
    assign misalign     = misalign_q;
    assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - directed self-checking bench for pc_fetch_ctrl
module tb_pc_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic [1:0]  jump_op;
    logic [31:0] rs_data;
    logic        commit;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        misalign;
    logic [15:0] redirect_cnt;

    int checks;
    int errors;

    pc_fetch_ctrl #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .jump_op      (jump_op),
        .rs_data      (rs_data),
        .commit       (commit),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .pc           (pc),
        .link_addr    (link_addr),
        .misalign     (misalign),
        .redirect_cnt (redirect_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        expect_eq("req_in_reset", 32'(imem_req), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // stall cycles of ready=0, then one ready cycle; checks the presented instr
    task automatic do_fetch(input logic [31:0] word, input int stall, input logic [31:0] addr);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            expect_eq("req_stall", 32'(imem_req), 32'd1);
            expect_eq("addr_stall", imem_addr, addr);
        end
        @(negedge clk);
        expect_eq("req", 32'(imem_req), 32'd1);
        expect_eq("addr", imem_addr, addr);
        imem_ready = 1'b1;
        imem_rdata = word;
        @(posedge clk); #1;
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        @(negedge clk);
        expect_eq("valid", 32'(instr_valid), 32'd1);
        expect_eq("instr", instr, word);
        expect_eq("req_issue", 32'(imem_req), 32'd0);
    endtask

    task automatic do_commit(input logic [1:0] op, input logic [31:0] rs,
                             input logic [31:0] exp_pc, input logic [15:0] exp_cnt);
        @(negedge clk);
        jump_op = op;
        rs_data = rs;
        commit  = 1'b1;
        @(posedge clk); #1;
        commit  = 1'b0;
        jump_op = 2'd3;
        rs_data = 32'h0;
        @(negedge clk);
        expect_eq("pc", pc, exp_pc);
        expect_eq("cnt", 32'(redirect_cnt), 32'(exp_cnt));
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        jump_op    = 2'd3;
        rs_data    = 32'h0;
        commit     = 1'b0;
        imem_ready = 1'b0;
        imem_rdata = 32'h0;

        do_reset();
        @(negedge clk);
        expect_eq("rst_pc", pc, 32'h0);
        expect_eq("rst_valid", 32'(instr_valid), 32'd0);
        expect_eq("rst_instr", instr, 32'h0);
        expect_eq("rst_misalign", 32'(misalign), 32'd0);
        expect_eq("rst_cnt", 32'(redirect_cnt), 32'd0);

        // ready on the third request cycle, then hold without commit
        do_fetch(32'h2008_0001, 2, 32'h0);
        @(negedge clk);
        expect_eq("hold_valid", 32'(instr_valid), 32'd1);
        expect_eq("hold_pc", pc, 32'h0);
`ifdef MIPS_DELAY_SLOT_EN
        expect_eq("link0", link_addr, 32'h8);
`else
        expect_eq("link0", link_addr, 32'h4);
`endif
        do_commit(2'd3, 32'h0, 32'h4, 16'd0);
        expect_eq("addr_after", imem_addr, 32'h4);
        expect_eq("req_after", 32'(imem_req), 32'd1);

`ifdef MIPS_DELAY_SLOT_EN
        for (int k = 1; k < 8; k++) begin
            do_fetch(32'h0, 0, 32'(k * 4));
            do_commit(2'd3, 32'h0, 32'((k + 1) * 4), 16'd0);
        end
        // beq at 0x20 to 0x80: offset (0x80-0x24)/4 = 0x17
        do_fetch(32'h1000_0017, 0, 32'h20);
        expect_eq("ds_link", link_addr, 32'h28);
        do_commit(2'd2, 32'h0, 32'h24, 16'd1);
        do_fetch(32'h0800_0100, 0, 32'h24);
        do_commit(2'd0, 32'h0, 32'h80, 16'd1);
        do_fetch(32'h0, 0, 32'h80);
`else
        // j 0x100 from pc 4
        do_fetch(32'h0800_0040, 0, 32'h4);
        do_commit(2'd0, 32'h0, 32'h100, 16'd1);
        // branch with imm -2 at 0x100 -> 0x104 - 8
        do_fetch(32'h1000_FFFE, 0, 32'h100);
        do_commit(2'd2, 32'h0, 32'h0FC, 16'd2);
        // aligned jr to 0x0040_0010
        do_fetch(32'h0, 1, 32'h0FC);
        do_commit(2'd1, 32'h0040_0010, 32'h0040_0010, 16'd3);
        // j from 0x0040_0010 keeps upper nibble 0 -> 0x100
        do_fetch(32'h0800_0040, 0, 32'h0040_0010);
        expect_eq("link_j", link_addr, 32'h0040_0014);
        do_commit(2'd0, 32'h0, 32'h100, 16'd4);
        // wrap at the top of the address space
        do_fetch(32'h0, 0, 32'h100);
        do_commit(2'd1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 16'd5);
        do_fetch(32'h0, 0, 32'hFFFF_FFFC);
        do_commit(2'd3, 32'h0, 32'h0, 16'd5);
        // ready while in ISSUE must not overwrite instr
        do_fetch(32'h0000_1111, 0, 32'h0);
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        imem_ready = 1'b0;
        @(negedge clk);
        expect_eq("issue_ready_ignored", instr, 32'h0000_1111);
        // misaligned jr halts with pc unchanged and no count
        do_commit(2'd1, 32'h0000_2002, 32'h0, 16'd5);
        expect_eq("misalign", 32'(misalign), 32'd1);
        expect_eq("halt_valid", 32'(instr_valid), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            expect_eq("halt_req", 32'(imem_req), 32'd0);
        end
        expect_eq("halt_pc", pc, 32'h0);
        do_reset();
        @(negedge clk);
        expect_eq("rec_misalign", 32'(misalign), 32'd0);
        expect_eq("rec_cnt", 32'(redirect_cnt), 32'd0);
        expect_eq("rec_req", 32'(imem_req), 32'd1);
`endif

        // reset in FETCH with a stale ready; move pc off RESET_PC first
        do_fetch(32'h0000_ABCD, 0, pc);
        do_commit(2'd3, 32'h0, pc + 32'd4, redirect_cnt);
        @(negedge clk);
        rst_n      = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        rst_n      = 1'b1;
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        @(negedge clk);
        expect_eq("mid_pc", pc, 32'h0);
        expect_eq("mid_valid", 32'(instr_valid), 32'd0);
        expect_eq("mid_instr", instr, 32'h0);
        expect_eq("mid_req", 32'(imem_req), 32'd1);
        @(negedge clk);
        expect_eq("mid_still_fetch", 32'(instr_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1);
    end

endmodule
